// File: rtl/uart_pkg.sv
// UART transmit drain: shared states and default constants.
// Imported by the drain FSM and its baud counter.
package uart_pkg;

    localparam int CLK_DIV_DEF    = 868;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int FRAME_BITS     = DATA_WIDTH_DEF + 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/uart_tx_drain_if.sv
// FIFO read port seen by the UART drain.
// The drain is the master: it owns the pop strobe.
interface uart_tx_drain_if #(
    parameter int DATA_WIDTH = 8
);

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_read_en;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_read_en
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_read_en
    );

endinterface

// File: rtl/baud_tick.sv
// Bit-period counter: counts 0..CLK_DIV-1 while enabled.
// Emits a one-cycle tick on the last count of each bit.
module baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap only at the bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from the FIFO and shifts each out as an 8N1 frame.
// tx comes from a flop; the pop strobe is a single IDLE cycle.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    uart_tx_drain_if.master fifo,
    output logic            tx,
    output logic            busy
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    state_t                state_q;
    state_t                state_d;
    logic [BW-1:0]         bit_q;
    logic [BW-1:0]         bit_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic                  tx_q;
    logic                  tx_d;
    logic                  pop;
    logic                  run;
    logic                  tick;

    assign run = state_q inside {START, DATA, STOP};

    baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .en    (run),
        .clr   (!run),
        .tick  (tick)
    );

    // FIFO output is only valid the cycle after this strobe.
    assign pop = !reset && (state_q == IDLE) && enable && !fifo.fifo_empty;

    assign fifo.fifo_read_en = pop;
    assign busy              = (state_q != IDLE) || pop;
    assign tx                = tx_q;

    // Next state, bit count and shift register.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                shift_d = fifo.fifo_data;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level follows the state being entered, so tx lines up with it.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State registers; reset aborts any frame and idles the line high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- Serial transmit stage directly downstream of the synchronous byte FIFO: pops one byte at a time from the FIFO read port and shifts it out as an 8N1 UART frame.
- Sits between the FIFO and the board TX pin.
- Owns the FIFO read strobe; the FIFO never pushes data into this block unprompted.

Parameters:
CLK_DIV, 868, clock cycles per UART bit (868 = 115200 baud at 100 MHz); legal range >= 2
DATA_WIDTH, 8, bits per frame payload; must match FIFO data width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  1 = allowed to start new frames; 0 = finish current frame then idle
fifo_empty  in  1  FIFO empty flag from upstream FIFO
fifo_data  in  DATA_WIDTH  FIFO output_data
fifo_read_en  out  1  one-cycle pop strobe to FIFO read_en
tx  out  1  UART serial line, idle high, registered
busy  out  1  1 from pop strobe until end of stop bit

Behaviour:
- One clock; reset is synchronous and active-high; every register is cleared on a clk edge with reset=1.
- Reset values: tx=1, fifo_read_en=0, busy=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- States: IDLE, FETCH, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If enable=1 and fifo_empty=0: drive fifo_read_en=1 for exactly this cycle and go to FETCH.
  - Otherwise stay in IDLE.
- FETCH (1 cycle):
  - fifo_read_en=0, busy=1.
  - FIFO output is valid the cycle after the read strobe; latch fifo_data into the shift register at the end of FETCH.
  - Go to START.
- START:
  - tx=0 for CLK_DIV cycles.
  - Baud counter counts 0..CLK_DIV-1; a bit boundary is reached at CLK_DIV-1, after which the counter returns to 0.
- DATA:
  - DATA_WIDTH bits, LSB first, each held CLK_DIV cycles.
  - Shift right at each bit boundary.
  - Bit counter 0..DATA_WIDTH-1; after the last bit go to STOP.
- STOP:
  - tx=1 for CLK_DIV cycles, then go to IDLE (busy falls on entry to IDLE).
- tx is driven from a register, never combinationally.
- First start-bit cycle on tx is 2 cycles after the fifo_read_en cycle (tx registered from state).
- Frame length on the line: (DATA_WIDTH+2)*CLK_DIV cycles exactly.
- Back-to-back frames:
  - A non-empty FIFO at STOP exit gives a pop in the first IDLE cycle.
  - The inter-frame idle gap is therefore exactly 2 cycles of tx=1 beyond the stop bit.
- fifo_empty and enable are ignored outside IDLE. Deasserting enable mid-frame completes the frame, and no further pop occurs.
- fifo_read_en is never asserted when fifo_empty=1, and never more than once per frame.
- Reset mid-frame: frame aborts, tx=1 and state=IDLE from the next edge, and the popped byte is discarded.
- Baud counter width: $clog2(CLK_DIV). Bit counter width: $clog2(DATA_WIDTH)+1. No counter may wrap except at the defined boundary.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, FETCH, START, DATA, STOP);
  - the default CLK_DIV and DATA_WIDTH constants;
  - the frame-bit-count constant FRAME_BITS = DATA_WIDTH+2.
- One natural sub-module, baud_tick:
  - free-running-when-enabled counter 0..CLK_DIV-1 with clear input;
  - emits a one-cycle tick at CLK_DIV-1.
- The FSM and shift register stay in uart_tx_drain.

Test Plan:
Run all scenarios with CLK_DIV=4, DATA_WIDTH=8, connected to the real FIFO.
1. Reset held 3 cycles with a non-empty FIFO -> tx=1, fifo_read_en=0 and busy=0 throughout; no pop occurs.
2. Push 0xA5, enable=1 ->
   - one fifo_read_en pulse;
   - tx low 2 cycles later for 4 cycles;
   - then bits 1,0,1,0,0,1,0,1 each 4 cycles, then stop high 4 cycles;
   - busy high for 42 cycles total.
3. Push 0x00, 0xFF, 0x3C back-to-back ->
   - three frames decoded by the bench UART monitor in order;
   - exactly 3 pops;
   - 2-cycle idle gap after each stop bit.
4. Pop 0x55 and deassert enable during DATA bit 3 -> frame completes correctly; no second pop while the FIFO still holds 0x66; popping resumes when enable returns to 1.
5. Assert reset at the 5th DATA bit of 0x81 -> tx=1 next cycle, state IDLE; after release, the next queued byte 0x7E is transmitted cleanly.
6. FIFO empty with enable=1 for 100 cycles -> zero pops and tx constant 1; a push of 0x12 then starts a frame within 3 cycles.
